// File: rtl/debug_uart_rx.sv
// debug_uart_rx: 32x-oversampling 8N1 receiver with a one-deep holding register and status flags
module debug_uart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_wr,
  input  logic [7:0] baud_div,
  input  logic [1:0] rx_sel,
  input  logic       rx1,
  input  logic       rx2,
  input  logic       rx3,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t     state_q;
  logic [7:0] div_q, pre_q, sh_q, data_q;
  logic [1:0] sel_q;
  logic [4:0] tc_q;
  logic [2:0] bit_q;
  logic       s1_q, s2_q, avail_q, ferr_q, ovr_q;
  logic       en, rx_mux, tick, smp16, smp32;
  assign en        = (div_q != 8'd0) && (sel_q != 2'd0);
  assign rx_mux    = sel_q == 2'd1 ? rx1 : sel_q == 2'd2 ? rx2 : sel_q == 2'd3 ? rx3 : 1'b1;
  assign tick      = pre_q == div_q - 8'd1;
  assign smp16     = tick && tc_q == 5'd15;
  assign smp32     = tick && tc_q == 5'd31;
  assign busy      = state_q != IDLE;
  assign rx_data   = data_q;
  assign rx_avail  = avail_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  // Baud/line-select config and a two-flop synchronizer on the selected line (idles high)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= 8'd0;
      sel_q <= 2'd0;
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
    end else begin
      if (baud_wr) begin
        div_q <= baud_div;
        sel_q <= rx_sel;
      end
      s1_q <= rx_mux;
      s2_q <= s1_q;
    end
  end
  // Oversampling counters, deframing FSM and the holding register with its status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= 8'd0;
      tc_q    <= 5'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      data_q  <= 8'd0;
      avail_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (rx_rd && avail_q) begin
        avail_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
      pre_q <= tick ? 8'd0 : pre_q + 8'd1;
      tc_q  <= tick ? tc_q + 5'd1 : tc_q;
      if (baud_wr || !en) state_q <= IDLE;
      else case (state_q)
        IDLE: begin
          pre_q <= 8'd0;
          tc_q  <= 5'd0;
          if (!s2_q) state_q <= START;
        end
        START: if (smp16) begin
          tc_q    <= 5'd0;
          bit_q   <= 3'd0;
          state_q <= s2_q ? IDLE : DATA;
        end
        DATA: if (smp32) begin
          tc_q  <= 5'd0;
          sh_q  <= {s2_q, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        STOP: if (smp32) begin
          tc_q    <= 5'd0;
          data_q  <= sh_q;
          avail_q <= 1'b1;
          ferr_q  <= ~s2_q;
          ovr_q   <= !rx_rd && (ovr_q || avail_q);
          state_q <= s2_q ? IDLE : WAIT_HI;
        end
        WAIT_HI: if (s2_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_uart_rx.sv
// tb_debug_uart_rx: scenario-task bench with a scoreboard of expected received bytes
module tb_debug_uart_rx;
  localparam int BT = 128;
  logic       clk = 1'b0, rst_n = 1'b0, baud_wr = 1'b0, rx_rd = 1'b0;
  logic [7:0] baud_div = 8'd0;
  logic [1:0] rx_sel = 2'd0;
  logic       rx1 = 1'b1, rx2 = 1'b1, rx3 = 1'b1;
  logic [7:0] rx_data;
  logic       rx_avail, frame_err, overrun, busy;
  typedef struct {logic [7:0] d; logic fe;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  debug_uart_rx dut (
    .clk(clk), .rst_n(rst_n), .baud_wr(baud_wr), .baud_div(baud_div), .rx_sel(rx_sel),
    .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_avail(rx_avail), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [2:0] m, input logic v);
    if (m[0]) rx1 = v;
    if (m[1]) rx2 = v;
    if (m[2]) rx3 = v;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [7:0] d, input logic [1:0] s);
    tick(1);
    baud_div = d;
    rx_sel   = s;
    baud_wr  = 1'b1;
    tick(1);
    baud_wr  = 1'b0;
  endtask
  task automatic pulse_rd();
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
  endtask
  task automatic send_byte(input logic [2:0] m, input logic [7:0] b, input logic stop, input bit exp);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (exp) sb.push_back('{d: b, fe: ~stop});
    tick(1);
    for (int i = 0; i < 10; i++) begin
      drive(m, f[i]);
      tick(BT);
    end
    if (stop) drive(m, 1'b1);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_chk++; if (rx_data !== 8'h00) $display("FAIL reset_data got %h exp 00", rx_data); else n_pass++;
    n_chk++; if (rx_avail !== 1'b0) $display("FAIL reset_avail got %b exp 0", rx_avail); else n_pass++;
    n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b exp 0", frame_err); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %b exp 0", overrun); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask
  task automatic test_basic();
    cfg(8'd4, 2'd2);
    tick(20);
    send_byte(3'b010, 8'hA5, 1'b1, 1);
    tick(10);
    n_chk++;
    if (sb.size() == 0) $display("FAIL basic_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d || frame_err !== e.fe) $display("FAIL basic_data got %h/%b exp %h/%b", rx_data, frame_err, e.d, e.fe); else n_pass++;
    end
    n_chk++; if (rx_avail !== 1'b1) $display("FAIL basic_avail got %b exp 1", rx_avail); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL basic_ovr got %b exp 0", overrun); else n_pass++;
    pulse_rd();
    n_chk++; if (rx_avail !== 1'b0) $display("FAIL basic_rd_avail got %b exp 0", rx_avail); else n_pass++;
  endtask
  task automatic test_false_start();
    tick(20);
    drive(3'b010, 1'b0);
    tick(20);
    n_chk++; if (busy !== 1'b1) $display("FAIL fs_busy_rise got %b exp 1", busy); else n_pass++;
    tick(20);
    drive(3'b010, 1'b1);
    tick(100);
    n_chk++; if (busy !== 1'b0) $display("FAIL fs_busy_fall got %b exp 0", busy); else n_pass++;
    n_chk++; if (rx_avail !== 1'b0) $display("FAIL fs_avail got %b exp 0", rx_avail); else n_pass++;
  endtask
  task automatic test_framing();
    send_byte(3'b010, 8'h3C, 1'b0, 1);
    tick(20);
    n_chk++;
    if (sb.size() == 0) $display("FAIL frame_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d || frame_err !== e.fe) $display("FAIL frame_data got %h/%b exp %h/%b", rx_data, frame_err, e.d, e.fe); else n_pass++;
    end
    tick(80);
    pulse_rd();
    tick(100);
    n_chk++; if (busy !== 1'b1) $display("FAIL frame_waithi_busy got %b exp 1", busy); else n_pass++;
    tick(182);
    drive(3'b010, 1'b1);
    tick(10);
    n_chk++; if (rx_avail !== 1'b0) $display("FAIL frame_no_second got %b exp 0", rx_avail); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL frame_idle got %b exp 0", busy); else n_pass++;
    send_byte(3'b010, 8'h55, 1'b1, 1);
    tick(10);
    n_chk++;
    if (sb.size() == 0) $display("FAIL frame55_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d || frame_err !== e.fe) $display("FAIL frame55_data got %h/%b exp %h/%b", rx_data, frame_err, e.d, e.fe); else n_pass++;
    end
    pulse_rd();
  endtask
  task automatic test_overrun();
    send_byte(3'b010, 8'h11, 1'b1, 1);
    tick(10);
    n_chk++;
    if (sb.size() == 0) $display("FAIL ovr1_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d) $display("FAIL ovr1_data got %h exp %h", rx_data, e.d); else n_pass++;
    end
    n_chk++; if (overrun !== 1'b0) $display("FAIL ovr1_flag got %b exp 0", overrun); else n_pass++;
    send_byte(3'b010, 8'h22, 1'b1, 1);
    tick(10);
    n_chk++;
    if (sb.size() == 0) $display("FAIL ovr2_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d) $display("FAIL ovr2_data got %h exp %h", rx_data, e.d); else n_pass++;
    end
    n_chk++; if (overrun !== 1'b1) $display("FAIL ovr2_flag got %b exp 1", overrun); else n_pass++;
    n_chk++; if (rx_avail !== 1'b1) $display("FAIL ovr2_avail got %b exp 1", rx_avail); else n_pass++;
    pulse_rd();
    n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b exp 0", overrun); else n_pass++;
  endtask
  task automatic test_collision();
    send_byte(3'b010, 8'h33, 1'b1, 1);
    tick(10);
    n_chk++;
    if (sb.size() == 0) $display("FAIL col1_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d) $display("FAIL col1_data got %h exp %h", rx_data, e.d); else n_pass++;
    end
    fork
      send_byte(3'b010, 8'h44, 1'b1, 1);
      begin
        tick(1);
        tick(1218);
        rx_rd = 1'b1;
        tick(1);
        rx_rd = 1'b0;
      end
    join
    tick(10);
    n_chk++;
    if (sb.size() == 0) $display("FAIL col2_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d) $display("FAIL col2_data got %h exp %h", rx_data, e.d); else n_pass++;
    end
    n_chk++; if (overrun !== 1'b0) $display("FAIL col_ovr got %b exp 0", overrun); else n_pass++;
    n_chk++; if (rx_avail !== 1'b1) $display("FAIL col_avail got %b exp 1", rx_avail); else n_pass++;
    pulse_rd();
  endtask
  task automatic test_disabled();
    int bc;
    logic [7:0] d_l [3];
    logic [1:0] s_l [3];
    logic [2:0] m_l [3];
    d_l = '{8'd4, 8'd0, 8'd4};
    s_l = '{2'd0, 2'd1, 2'd3};
    m_l = '{3'b111, 3'b111, 3'b001};
    for (int k = 0; k < 3; k++) begin
      cfg(d_l[k], s_l[k]);
      bc = 0;
      fork
        send_byte(m_l[k], 8'h0F, 1'b1, 0);
        repeat (1300) begin
          @(negedge clk);
          if (busy) bc++;
        end
      join
      n_chk++; if (bc !== 0) $display("FAIL dis%0d_busy got %0d exp 0", k, bc); else n_pass++;
      n_chk++; if (rx_avail !== 1'b0) $display("FAIL dis%0d_avail got %b exp 0", k, rx_avail); else n_pass++;
    end
  endtask
  task automatic test_abort();
    cfg(8'd4, 2'd2);
    tick(10);
    send_byte(3'b010, 8'h5A, 1'b1, 1);
    tick(10);
    n_chk++;
    if (sb.size() == 0) $display("FAIL abort_pre_sb empty");
    else begin
      e = sb.pop_front();
      if (rx_data !== e.d) $display("FAIL abort_pre_data got %h exp %h", rx_data, e.d); else n_pass++;
    end
    fork
      send_byte(3'b010, 8'hFE, 1'b1, 0);
      begin
        tick(500);
        n_chk++; if (busy !== 1'b1) $display("FAIL abort_mid_busy got %b exp 1", busy); else n_pass++;
        cfg(8'd4, 2'd2);
        n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
      end
    join
    tick(20);
    n_chk++; if (rx_data !== 8'h5A) $display("FAIL abort_keep_data got %h exp 5a", rx_data); else n_pass++;
    n_chk++; if (rx_avail !== 1'b1) $display("FAIL abort_keep_avail got %b exp 1", rx_avail); else n_pass++;
  endtask
  task automatic test_reset_mid();
    fork
      send_byte(3'b010, 8'hFE, 1'b1, 0);
      begin
        tick(500);
        n_chk++; if (busy !== 1'b1) $display("FAIL rstmid_busy_pre got %b exp 1", busy); else n_pass++;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_chk++; if (rx_data !== 8'h00) $display("FAIL rstmid_data got %h exp 00", rx_data); else n_pass++;
        n_chk++; if (rx_avail !== 1'b0) $display("FAIL rstmid_avail got %b exp 0", rx_avail); else n_pass++;
        n_chk++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr got %b exp 0", frame_err); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL rstmid_ovr got %b exp 0", overrun); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else n_pass++;
      end
    join
  endtask
  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_overrun();
    test_collision();
    test_disabled();
    test_abort();
    test_reset_mid();
    tick(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/debug_uart_rx.md
# debug_uart_rx

Debug-port UART receiver that sits directly downstream of the debug auto-baud detector. It latches the detected divisor and selected RX input, then oversamples the chosen line at 32 ticks per bit. It deframes 8N1 characters and presents each byte in a one-deep holding register with read-acknowledge, frame-error and overrun status for the debug command decoder.

## Interface
Parameters: none.

- clk  input  1  system clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- baud_wr  input  1  one-clk pulse: latch baud_div and rx_sel
- baud_div  input  8  clocks per oversample tick (bit time = 32*baud_div clocks)
- rx_sel  input  2  0 = none, 1/2/3 = rx1/rx2/rx3
- rx1, rx2, rx3  input  1 each  candidate asynchronous serial inputs, idle high
- rx_rd  input  1  one-clk pulse: consume the held byte, clear status
- rx_data  output  8  last received byte
- rx_avail  output  1  holding register contains an unread byte
- frame_err  output  1  stop bit of the last byte sampled low
- overrun  output  1  a byte was overwritten before being read
- busy  output  1  FSM not in IDLE

## Operation
- Config registers div_q (8b) and sel_q (2b) load on baud_wr. Reset value is 0 for both. The receiver is enabled only when div_q != 0 and sel_q != 0. While disabled, the FSM is held in IDLE.
- RX mux: sel_q 1/2/3 selects rx1/rx2/rx3. sel_q = 0 forces 1. The mux output passes through a 2-flop synchronizer, reset to 1, giving rxs.
- Prescaler: 8b counter runs 0..div_q-1. tick is asserted in the cycle the count equals div_q-1, and the count wraps to 0 on that cycle. Tick counter: 5b, advances on tick. Both counters clear on leaving IDLE and after each sample.
- FSM states:
  - IDLE: when enabled and rxs == 0, go to START.
  - START: on the 16th tick (tick with tick_cnt == 15), sample rxs. If 0, go to DATA with bit_cnt = 0. If 1, it is a false start: go to IDLE.
  - DATA: on the 32nd tick, shift rxs into bit 7 of the shift register (shift right, LSB first). After the 8th bit, go to STOP.
  - STOP: on the 32nd tick, load the shift register into rx_data, set rx_avail, and set frame_err = ~rxs. If rxs == 1, go to IDLE; else go to WAIT_HI.
  - WAIT_HI: wait for rxs == 1, then go to IDLE (a break or stuck-low line never restarts reception).
- Overrun: if rx_avail = 1 at the STOP load and rx_rd is not asserted in that cycle, set overrun. rx_data is overwritten with the new byte.
- rx_rd: clears rx_avail, overrun and frame_err on the next edge. If rx_rd coincides with the STOP load, the load wins: rx_avail stays 1, frame_err takes the new value, and overrun is not set.
- baud_wr during a frame: the FSM aborts to IDLE and the partial byte is discarded. Holding register and status are untouched.
- rx_rd while rx_avail = 0: no effect.

## Timing
- Reset values: rx_data = 0x00, rx_avail = 0, frame_err = 0, overrun = 0, busy = 0. The synchronizer resets to 1.
- Config takes effect the cycle after baud_wr.
- Start detect: rxs lags the pin by 2 clocks. busy rises 1 clock after rxs first reads 0.
- Start sample occurs 16*div_q clocks after entering START. Each subsequent sample follows 32*div_q clocks later.
- rx_avail, rx_data and frame_err update 1 clock after the STOP sample tick. The total from pin falling edge is about 2 + 1 + 16*D + 9*32*D + 1 clocks.
- Status clears 1 clock after the rx_rd pulse.
- Transfer between the idle→start edge and the first clock does not depend on baud_wr phase.

## Test plan
- Basic byte: baud_wr with div = 4, rx_sel = 2. Drive 0xA5 on rx2 (8N1, 128 clk/bit), rx1/rx3 held high → rx_data = 0xA5, rx_avail = 1, frame_err = 0, overrun = 0. rx_rd → rx_avail = 0 next clock.
- False start: div = 4, low glitch of 40 clocks on the selected line → FSM returns to IDLE, busy falls, rx_avail stays 0.
- Framing: send 0x3C with stop bit low, then hold the line low for 3 bit times → rx_data = 0x3C, frame_err = 1. No second byte is received until the line returns high. Next valid 0x55 → frame_err = 0.
- Overrun and collision: send 0x11 then 0x22 without rx_rd → overrun = 1, rx_data = 0x22. Repeat with rx_rd pulsed in the same cycle as the second load → overrun = 0, rx_avail = 1.
- Disabled/mux: rx_sel = 0 or div = 0, traffic on all inputs → busy stays 0. rx_sel = 3 with traffic on rx1 only → nothing received.
- Abort/reset: baud_wr mid-frame → FSM returns to IDLE, prior rx_data is kept. rst_n low mid-frame → all outputs return to their reset values the next clock.
